// File: rtl/ob_tristate_release_seq.sv
// Power-up / safe-state sequencer for output buffers: holds global tristate after reset,
// then releases TSALL and each OE group in turn with programmable spacing.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// HOLD       | idle, TSALL=1, OE=0, waiting for EN
// WAIT_INIT  | counting INIT_DLY before TSALL release
// RELEASE    | TSALL released, stepping OE groups every STEP_DLY cycles
// RUN        | all groups driving, DONE=1
// SAFE_ST    | forced high-Z while SAFE is held
module ob_tristate_release_seq #(
    parameter int NGRP     = 4,
    parameter int INIT_DLY = 16,
    parameter int STEP_DLY = 4,
    parameter int CW       = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            en_i,
    input  logic            safe_i,
    output logic            tsall_o,
    output logic [NGRP-1:0] oe_o,
    output logic            busy_o,
    output logic            done_o
);

    localparam int IW = (NGRP > 1) ? $clog2(NGRP) : 1;

    localparam logic [2:0] ST_HOLD      = 3'd0;
    localparam logic [2:0] ST_WAIT_INIT = 3'd1;
    localparam logic [2:0] ST_RELEASE   = 3'd2;
    localparam logic [2:0] ST_RUN       = 3'd3;
    localparam logic [2:0] ST_SAFE      = 3'd4;

    localparam logic [CW-1:0] INIT_LOAD = CW'(INIT_DLY - 1);
    localparam logic [CW-1:0] STEP_LOAD = CW'(STEP_DLY - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NGRP - 1);

    logic [2:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            tsall_q, tsall_d;
    logic [NGRP-1:0] oe_q, oe_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic seq_active;
    assign seq_active = (state_q == ST_WAIT_INIT) || (state_q == ST_RELEASE) || (state_q == ST_RUN);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        tsall_d = tsall_q;
        oe_d    = oe_q;
        busy_d  = busy_q;
        done_d  = done_q;

        if (safe_i) begin
            state_d = ST_SAFE;
            cnt_d   = '0;
            idx_d   = '0;
            tsall_d = 1'b1;
            oe_d    = '0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end else if (!en_i && seq_active) begin
            // Abort drops everything; no partial release survives.
            state_d = ST_HOLD;
            cnt_d   = '0;
            idx_d   = '0;
            tsall_d = 1'b1;
            oe_d    = '0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (en_i) begin
                        state_d = ST_WAIT_INIT;
                        cnt_d   = INIT_LOAD;
                        busy_d  = 1'b1;
                    end
                end
                ST_WAIT_INIT: begin
                    if (cnt_q == '0) begin
                        state_d = ST_RELEASE;
                        tsall_d = 1'b0;
                        cnt_d   = STEP_LOAD;
                        idx_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                ST_RELEASE: begin
                    if (cnt_q == '0) begin
                        for (int i = 0; i < NGRP; i++) begin
                            if (IW'(i) == idx_q) begin
                                oe_d[i] = 1'b1;
                            end
                        end
                        if (idx_q == IDX_LAST) begin
                            state_d = ST_RUN;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end else begin
                            idx_d = idx_q + IW'(1);
                            cnt_d = STEP_LOAD;
                        end
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                ST_RUN: begin
                    state_d = ST_RUN;
                end
                ST_SAFE: begin
                    state_d = ST_HOLD;
                end
                default: begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                    idx_d   = '0;
                    tsall_d = 1'b1;
                    oe_d    = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            tsall_q <= 1'b1;
            oe_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            tsall_q <= tsall_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tsall_o = tsall_q;
    assign oe_o    = oe_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule

// File: tb/tb_ob_tristate_release_seq.sv
// Scoreboard bench: stimulus pushes expected outputs keyed by edge number,
// a negedge monitor pops and compares them against two DUT configurations.
module tb_ob_tristate_release_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    // default configuration
    logic       rst = 1'b1, en = 1'b0, safe = 1'b0;
    logic       tsall0, busy0, done0;
    logic [3:0] oe0;

    ob_tristate_release_seq dut0 (
        .clk_i  (clk),
        .rst_i  (rst),
        .en_i   (en),
        .safe_i (safe),
        .tsall_o(tsall0),
        .oe_o   (oe0),
        .busy_o (busy0),
        .done_o (done0)
    );

    // minimal configuration: one group, unit delays
    logic       rst1 = 1'b1, en1 = 1'b0, safe1 = 1'b0;
    logic       tsall1, busy1, done1;
    logic [0:0] oe1;

    ob_tristate_release_seq #(.NGRP(1), .INIT_DLY(1), .STEP_DLY(1), .CW(4)) dut1 (
        .clk_i  (clk),
        .rst_i  (rst1),
        .en_i   (en1),
        .safe_i (safe1),
        .tsall_o(tsall1),
        .oe_o   (oe1),
        .busy_o (busy1),
        .done_o (done1)
    );

    typedef struct {
        int         e;
        int         dut;
        logic       ts;
        logic [3:0] oe;
        logic       busy;
        logic       done;
        string      nm;
    } exp_t;

    exp_t sb[$];
    int tests = 0;
    int fails = 0;

    task automatic push(input int e, input int d, input logic ts, input logic [3:0] oe,
                        input logic b, input logic dn, input string nm);
        exp_t x;
        x.e = e; x.dut = d; x.ts = ts; x.oe = oe; x.busy = b; x.done = dn; x.nm = nm;
        sb.push_back(x);
    endtask

    task automatic goto(input int e);
        while (edge_n < e) @(negedge clk);
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].e <= edge_n) begin
            exp_t x;
            logic [6:0] act, want;
            x = sb.pop_front();
            act  = (x.dut == 0) ? {tsall0, oe0, busy0, done0}
                                : {tsall1, 3'b000, oe1, busy1, done1};
            want = {x.ts, x.oe, x.busy, x.done};
            tests++;
            if (x.e < edge_n) begin
                fails++;
                $display("FAIL %s: check for edge %0d missed (now %0d)", x.nm, x.e, edge_n);
            end else if (act !== want) begin
                fails++;
                $display("FAIL %s @edge %0d dut%0d: got ts=%b oe=%b busy=%b done=%b, want ts=%b oe=%b busy=%b done=%b",
                         x.nm, edge_n, x.dut, act[6], act[5:2], act[1], act[0],
                         want[6], want[5:2], want[1], want[0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, %0d checks pending", sb.size());
        $fatal(1, "timeout");
    end

    initial begin
        int b, c;

        goto(2);
        push(3, 0, 1, 4'h0, 0, 0, "rst_d0");
        push(3, 1, 1, 4'h0, 0, 0, "rst_d1");
        goto(3);
        rst = 1'b0; rst1 = 1'b0;
        push(4, 0, 1, 4'h0, 0, 0, "hold_idle");
        goto(4);

        // full release sequence
        b = edge_n + 1; en = 1'b1;
        push(b,      0, 1, 4'h0, 1, 0, "seq_start");
        push(b + 15, 0, 1, 4'h0, 1, 0, "ts_before");
        push(b + 16, 0, 0, 4'h0, 1, 0, "ts_fall");
        push(b + 19, 0, 0, 4'h0, 1, 0, "oe0_before");
        push(b + 20, 0, 0, 4'h1, 1, 0, "oe0");
        push(b + 24, 0, 0, 4'h3, 1, 0, "oe1");
        push(b + 28, 0, 0, 4'h7, 1, 0, "oe2");
        push(b + 31, 0, 0, 4'h7, 1, 0, "oe3_before");
        push(b + 32, 0, 0, 4'hF, 0, 1, "done");
        push(b + 40, 0, 0, 4'hF, 0, 1, "run_hold");
        goto(b + 40);

        // safe from RUN, exit with EN still high
        c = edge_n; safe = 1'b1;
        push(c + 1, 0, 1, 4'h0, 0, 0, "safe_enter");
        push(c + 3, 0, 1, 4'h0, 0, 0, "safe_hold");
        goto(c + 3);
        safe = 1'b0;
        push(c + 4,  0, 1, 4'h0, 0, 0, "safe_exit_hold");
        push(c + 5,  0, 1, 4'h0, 1, 0, "restart");
        push(c + 20, 0, 1, 4'h0, 1, 0, "re_ts_before");
        push(c + 21, 0, 0, 4'h0, 1, 0, "re_ts_fall");
        b = c + 5;
        push(b + 20, 0, 0, 4'h1, 1, 0, "re_oe0");
        push(b + 22, 0, 0, 4'h1, 1, 0, "pre_abort");
        goto(b + 22);

        // abort with one group released
        en = 1'b0;
        push(b + 23, 0, 1, 4'h0, 0, 0, "abort");
        goto(b + 23);
        en = 1'b1; b = edge_n + 1;
        push(b,      0, 1, 4'h0, 1, 0, "ab_restart");
        push(b + 15, 0, 1, 4'h0, 1, 0, "ab_ts_before");
        push(b + 16, 0, 0, 4'h0, 1, 0, "ab_ts_fall");
        push(b + 24, 0, 0, 4'h3, 1, 0, "ab_oe1");
        goto(b + 25);

        // reset mid-release, EN held high
        rst = 1'b1;
        push(b + 26, 0, 1, 4'h0, 0, 0, "rst_mid");
        goto(b + 26);
        rst = 1'b0;
        push(b + 27, 0, 1, 4'h0, 1, 0, "rst_restart");
        push(b + 42, 0, 1, 4'h0, 1, 0, "rst_ts_before");
        push(b + 43, 0, 0, 4'h0, 1, 0, "rst_ts_fall");
        goto(b + 43);

        // abort, then SAFE and EN together in HOLD
        en = 1'b0; c = edge_n;
        push(c + 1, 0, 1, 4'h0, 0, 0, "abort_release");
        goto(c + 1);
        en = 1'b1; safe = 1'b1;
        push(c + 2, 0, 1, 4'h0, 0, 0, "safe_en_same");
        push(c + 6, 0, 1, 4'h0, 0, 0, "safe_en_hold");
        goto(c + 6);
        safe = 1'b0; en = 1'b0;
        push(c + 7, 0, 1, 4'h0, 0, 0, "safe_release_idle");
        goto(c + 7);

        // SAFE on the edge OE[0] would rise
        en = 1'b1;
        push(c + 27, 0, 0, 4'h0, 1, 0, "pre_oe_safe");
        goto(c + 27);
        safe = 1'b1;
        push(c + 28, 0, 1, 4'h0, 0, 0, "safe_beats_oe");
        goto(c + 28);
        safe = 1'b0; en = 1'b0;

        // one group, unit delays
        b = edge_n + 1; en1 = 1'b1;
        push(b,     1, 1, 4'h0, 1, 0, "d1_start");
        push(b + 1, 1, 0, 4'h0, 1, 0, "d1_ts_fall");
        push(b + 2, 1, 0, 4'h1, 0, 1, "d1_done");
        push(b + 4, 1, 0, 4'h1, 0, 1, "d1_run");
        goto(b + 4);
        en1 = 1'b0;
        push(b + 5, 1, 1, 4'h0, 0, 0, "d1_abort");
        goto(b + 7);
        @(negedge clk);
        #1;

        while (sb.size() > 0) begin
            exp_t x;
            x = sb.pop_front();
            tests++;
            fails++;
            $display("FAIL %s: check for edge %0d never reached", x.nm, x.e);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ob_tristate_release_seq.md
Name: ob_tristate_release_seq

Overview:
- Power-up and safe-state sequencer for the device output buffers.
- Holds the global tristate net (TSALL) asserted after reset, then releases the output buffers in stages: a global release first, then each output group in turn, with programmable spacing.
- Provides an immediate safe-state request that returns all outputs to high-Z.
- Sits between board/system control logic and the OB-style buffers, which drive only while TSALL is low.

Parameters:
- NGRP, 4: number of output groups (one OE bit each); must be >= 1.
- INIT_DLY, 16: cycles from accepted EN to TSALL release; must be >= 1.
- STEP_DLY, 4: cycles between TSALL release and OE[0], and between consecutive OE bits; must be >= 1.
- CW, 8: down-counter width; must hold max(INIT_DLY, STEP_DLY)-1.

Ports:
- CLK, input, 1: single clock; all state changes on the rising edge.
- RST, input, 1: synchronous, active-high reset.
- EN, input, 1: level request to run and keep the release sequence.
- SAFE, input, 1: level request to force all outputs to high-Z.
- TSALL, output, 1: global tristate, 1 = all buffers high-Z.
- OE, output, NGRP: per-group output enable, 1 = group driving.
- BUSY, output, 1: sequence in progress (WAIT_INIT or RELEASE).
- DONE, output, 1: all groups released (RUN).

Behaviour:
- Reset (RST=1 at an edge) is the highest priority. Result: TSALL=1, OE=0, BUSY=0, DONE=0, state HOLD, counter=0, group index=0.
- All outputs are registered. No combinational path exists from inputs to outputs.
- Priority at each edge outside reset: SAFE, then EN low (abort), then normal transitions.

States:
- HOLD: TSALL=1, OE=0. If EN=1 and SAFE=0, go to WAIT_INIT, counter=INIT_DLY-1, BUSY=1.
- WAIT_INIT: counter decrements each edge. At an edge where counter==0: TSALL<=0, go to RELEASE, counter=STEP_DLY-1, index=0.
- RELEASE: counter decrements each edge. At an edge where counter==0: OE[index]<=1.
  - If index==NGRP-1: go to RUN, DONE<=1, BUSY<=0.
  - Else: index++, counter=STEP_DLY-1.
- RUN: hold TSALL=0, OE all ones, DONE=1.
- SAFE_ST: TSALL=1, OE=0, BUSY=0, DONE=0. Remain while SAFE=1. Go to HOLD at the first edge with SAFE=0.

Timing:
- With EN sampled high at edge e0 in HOLD:
  - TSALL falls at edge e0+INIT_DLY.
  - OE[k] rises at edge e0+INIT_DLY+(k+1)*STEP_DLY.
  - DONE rises at the same edge as OE[NGRP-1]; BUSY falls at that edge.
- OE bits only ever rise in ascending index order and never rise while TSALL=1.

Boundary conditions:
- SAFE=1 in any state: the next edge gives TSALL=1, OE=0, BUSY=0, DONE=0, state SAFE_ST. This includes mid-count and the cycle OE would have risen; SAFE wins.
- EN=0 in WAIT_INIT, RELEASE or RUN (SAFE=0): the next edge gives TSALL=1, OE=0, BUSY=0, DONE=0, state HOLD. No partial release is retained.
- EN=1 and SAFE=1 simultaneously in HOLD: go to SAFE_ST.
- Leaving SAFE_ST with EN still high: HOLD for one edge, then restart from WAIT_INIT. The full INIT_DLY applies again.
- INIT_DLY=1 / STEP_DLY=1: TSALL falls at e0+1; OE bits rise on consecutive edges.
- NGRP=1: DONE coincides with OE[0].
- The counter never wraps. It is reloaded only on entry to WAIT_INIT and on each RELEASE step.
- RST mid-sequence behaves exactly as reset from power-up.

Test Plan:
- Defaults; RST pulse, then EN=1 at edge e0 -> TSALL=1 through e15, 0 at e16. OE=0001 at e20, 0011 at e24, 0111 at e28, 1111 at e32. DONE=1 and BUSY=0 at e32; BUSY=1 e0..e31.
- Reach RUN, then SAFE=1 for 3 edges -> next edge TSALL=1, OE=0000, DONE=0; SAFE_ST held. SAFE=0 with EN=1 -> HOLD one edge, then a fresh sequence: TSALL falls 16 edges after re-entry.
- Abort: EN falls at e22 (OE=0001) -> e23 gives TSALL=1, OE=0000, BUSY=0. EN re-raised -> full sequence from the start.
- SAFE and EN rise on the same edge in HOLD -> SAFE_ST, TSALL stays 1, BUSY never asserts.
- NGRP=1, INIT_DLY=1, STEP_DLY=1: EN at e0 -> TSALL=0 at e1; OE=1, DONE=1 at e2.
- RST asserted at e26 mid-RELEASE -> e26 outputs TSALL=1, OE=0000, BUSY=0, DONE=0. With EN held high, the sequence restarts after RST deasserts.
